// File: rtl/tca_histogram.sv
// tca_histogram: TDC start/end histogram. Four banks x 64 interval bins of
//   COUNT_W-bit counters in a 256-entry 1R1W RAM, plus event, coincidence and drop totals.
// Ports: clk, rst (async, active high); START_signal/END_signal/INTERVAL/data_arrived
//   carry TDC events. clear/busy control the zeroing sweep. rd_req/rd_addr/rd_ack/
//   rd_valid/rd_data form the host read port. coinc_count/event_count/drop_count are totals.
// Update path: E0 edge detect -> E1 RAM read -> E2 increment+write; visible to reads from E3.
// Build option: define TCA_HIST_SATURATE_EN to make bins saturate at all-ones instead of wrapping.
module tca_histogram #(
  parameter int COUNT_W = 16,
  parameter int TOTAL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         START_signal,
  input  logic [1:0]         END_signal,
  input  logic [5:0]         INTERVAL,
  input  logic               data_arrived,
  input  logic               clear,
  output logic               busy,
  input  logic               rd_req,
  input  logic [7:0]         rd_addr,
  output logic               rd_ack,
  output logic               rd_valid,
  output logic [COUNT_W-1:0] rd_data,
  output logic [TOTAL_W-1:0] coinc_count,
  output logic [TOTAL_W-1:0] event_count,
  output logic [TOTAL_W-1:0] drop_count
);

  logic [COUNT_W-1:0] mem [256];
  logic [COUNT_W-1:0] ram_q;
  logic [COUNT_W-1:0] wr_last;
  logic [COUNT_W-1:0] base;
  logic [COUNT_W-1:0] inc;
  logic               da_q;
  logic               start_pend;
  logic [7:0]         sweep_addr;
  logic               e1_vld;
  logic               e2_vld;
  logic               e2_fwd;
  logic [7:0]         e1_addr;
  logic [7:0]         e2_addr;
  logic [TOTAL_W-1:0] pend_drop;
  logic               evt;
  logic               is_coinc;
  logic               map_ok;
  logic               is_drop;
  logic [1:0]         bank;
  logic               sweep_go;
  logic               ack_ok;
  logic               we;
  logic [7:0]         wa;
  logic [COUNT_W-1:0] wd;

  assign evt      = data_arrived & ~da_q;
  assign is_coinc = (END_signal == 2'b11) && (INTERVAL == 6'd0);

  always_comb begin
    map_ok = 1'b1;
    bank   = 2'd0;
    case ({START_signal, END_signal})
      4'b10_01: bank = 2'd0;
      4'b01_10: bank = 2'd1;
      4'b10_10: bank = 2'd2;
      4'b01_01: bank = 2'd3;
      default:  map_ok = 1'b0;
    endcase
  end

  assign is_drop = ~is_coinc & ~map_ok;

  // A clear request (or the post-reset pending sweep) starts a sweep only when idle.
  assign sweep_go = (clear | start_pend) & ~busy;

  // Host reads wait until no update is in flight (E1 or E2), so the returned value
  // always includes every event accepted before the request was granted.
  assign ack_ok = rd_req & ~busy & ~sweep_go & ~e1_vld & ~e2_vld;
  assign rd_ack = ack_ok;

  // Forwarding covers an E1 read racing the E2 write of the same bin.
  assign base = e2_fwd ? wr_last : ram_q;

`ifdef TCA_HIST_SATURATE_EN
  assign inc = (&base) ? base : base + COUNT_W'(1);
`else
  assign inc = base + COUNT_W'(1);
`endif

  assign we = busy | (e2_vld & ~sweep_go);
  assign wa = busy ? sweep_addr : e2_addr;
  assign wd = busy ? '0 : inc;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Single read port: E1 update reads take precedence over host reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_q <= '0;
    else if (e1_vld || ack_ok) ram_q <= mem[e1_vld ? e1_addr : rd_addr];
  end

  assign rd_data = ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      da_q        <= 1'b1;  // a strobe already high at release is not an edge
      start_pend  <= 1'b1;
      busy        <= 1'b0;
      sweep_addr  <= 8'd0;
      e1_vld      <= 1'b0;
      e1_addr     <= 8'd0;
      e2_vld      <= 1'b0;
      e2_addr     <= 8'd0;
      e2_fwd      <= 1'b0;
      wr_last     <= '0;
      rd_valid    <= 1'b0;
      pend_drop   <= '0;
      coinc_count <= '0;
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      da_q     <= data_arrived;
      rd_valid <= ack_ok;
      e1_vld   <= 1'b0;
      e2_vld   <= e1_vld;
      e2_addr  <= e1_addr;
      e2_fwd   <= e1_vld & e2_vld & (e1_addr == e2_addr);
      if (e2_vld) wr_last <= inc;

      if (sweep_go) begin
        // Everything in flight is discarded; totals read zero in the first busy cycle.
        start_pend  <= 1'b0;
        busy        <= 1'b1;
        sweep_addr  <= 8'd0;
        e2_vld      <= 1'b0;
        pend_drop   <= '0;
        coinc_count <= '0;
        event_count <= '0;
        drop_count  <= '0;
      end else if (busy) begin
        sweep_addr <= sweep_addr + 8'd1;
        if (sweep_addr == 8'hFF) busy <= 1'b0;
        if (evt) begin
          event_count <= event_count + TOTAL_W'(1);
          if (pend_drop != {TOTAL_W{1'b1}}) pend_drop <= pend_drop + TOTAL_W'(1);
        end
      end else begin
        if (evt) begin
          event_count <= event_count + TOTAL_W'(1);
          if (is_coinc) coinc_count <= coinc_count + TOTAL_W'(1);
          else if (map_ok) begin
            e1_vld  <= 1'b1;
            e1_addr <= {bank, INTERVAL};
          end
        end
        // Drops held back during the sweep are folded in once it is over.
        drop_count <= drop_count + pend_drop + TOTAL_W'(evt & is_drop);
        pend_drop  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tca_histogram.sv
// tb_tca_histogram: scoreboard bench for tca_histogram. A narrow bin counter
// (COUNT_W = 8) keeps the all-ones preload of the saturation scenario short.
// Expected read data is pushed when a read is issued and popped when rd_valid returns.
module tb_tca_histogram;

  localparam int CW = 8;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    START_signal = 2'b00;
  logic [1:0]    END_signal = 2'b00;
  logic [5:0]    INTERVAL = 6'd0;
  logic          data_arrived = 1'b1;
  logic          clear = 1'b0;
  logic          busy;
  logic          rd_req = 1'b0;
  logic [7:0]    rd_addr = 8'd0;
  logic          rd_ack;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [TW-1:0] coinc_count;
  logic [TW-1:0] event_count;
  logic [TW-1:0] drop_count;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] model [256];
  logic [TW-1:0] m_event = '0;
  logic [TW-1:0] m_coinc = '0;
  logic [TW-1:0] m_drop  = '0;

  tca_histogram #(.COUNT_W(CW), .TOTAL_W(TW)) dut (
    .clk(clk), .rst(rst),
    .START_signal(START_signal), .END_signal(END_signal), .INTERVAL(INTERVAL),
    .data_arrived(data_arrived), .clear(clear), .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .coinc_count(coinc_count), .event_count(event_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bump(input logic [7:0] a);
`ifdef TCA_HIST_SATURATE_EN
    if (model[a] != {CW{1'b1}}) model[a] = model[a] + 1'b1;
`else
    model[a] = model[a] + 1'b1;
`endif
  endtask

  // Drive one TDC event (strobe high for 'hold' cycles, then low) and update the model.
  task automatic ev(input logic [1:0] s, input logic [1:0] e, input logic [5:0] iv, input int hold);
    START_signal = s; END_signal = e; INTERVAL = iv;
    data_arrived = 1'b1;
    repeat (hold) tick;
    data_arrived = 1'b0;
    tick;
    m_event = m_event + 1;
    if (e == 2'b11 && iv == 6'd0) m_coinc = m_coinc + 1;
    else if (s == 2'b10 && e == 2'b01) bump({2'd0, iv});
    else if (s == 2'b01 && e == 2'b10) bump({2'd1, iv});
    else if (s == 2'b10 && e == 2'b10) bump({2'd2, iv});
    else if (s == 2'b01 && e == 2'b01) bump({2'd3, iv});
    else m_drop = m_drop + 1;
  endtask

  // Issue one host read; ok is low if no grant/valid arrived within the budget.
  task automatic do_read(input logic [7:0] a, output logic [CW-1:0] d, output bit ok);
    bit acked = 1'b0;
    ok = 1'b0;
    d = '0;
    rd_req = 1'b1;
    rd_addr = a;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_ack) begin
        acked = 1'b1;
        break;
      end
      tick;
    end
    tick;
    rd_req = 1'b0;
    if (acked) begin
      @(negedge clk);
      ok = rd_valid;
      d = rd_data;
    end
    tick;
  endtask

  task automatic test_reset;
    logic [7:0] addrs [5];
    logic [CW-1:0] d, exp;
    bit ok;
    int busy_cycles = 0;
    int rise_wait = 0;
    addrs = '{8'h00, 8'h05, 8'h45, 8'hC3, 8'hFF};
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_ack !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b rd_ack=%b rd_valid=%b required 0/0/0", busy, rd_ack, rd_valid);
    end
    checks++;
    if (rd_data !== '0 || event_count !== '0 || coinc_count !== '0 || drop_count !== '0) begin
      errors++;
      $display("FAIL reset_data rd_data=%0h ev=%0d co=%0d dr=%0d required all 0",
               rd_data, event_count, coinc_count, drop_count);
    end
    tick;
    rst = 1'b0;  // data_arrived stays high across release
    @(negedge clk);
    while (!busy && rise_wait < 4) begin
      tick;
      @(negedge clk);
      rise_wait++;
    end
    checks++;
    if (rise_wait != 1) begin
      errors++;
      $display("FAIL reset_busy_rise waited=%0d cycles required 1", rise_wait);
    end
    while (busy && busy_cycles < 400) begin
      busy_cycles++;
      tick;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != 256) begin
      errors++;
      $display("FAIL reset_busy_len busy=%0d cycles required 256", busy_cycles);
    end
    data_arrived = 1'b0;
    tick;
    tick;
    @(negedge clk);
    checks++;
    if (event_count !== m_event) begin
      errors++;
      $display("FAIL reset_no_edge event_count=%0d required %0d", event_count, m_event);
    end
    for (int i = 0; i < 256; i++) model[i] = '0;
    foreach (addrs[i]) begin
      exp_q.push_back(model[addrs[i]]);
      do_read(addrs[i], d, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || d !== exp) begin
        errors++;
        $display("FAIL reset_read[%02h] got=%0h valid=%b required %0h", addrs[i], d, ok, exp);
      end
    end
  endtask

  task automatic test_bank_event;
    logic [7:0] addrs [4];
    logic [CW-1:0] d, exp;
    bit ok;
    addrs = '{8'h05, 8'h47, 8'h89, 8'hFF};
    ev(2'b10, 2'b01, 6'd5, 2);
    ev(2'b01, 2'b10, 6'd7, 1);
    ev(2'b10, 2'b10, 6'd9, 3);
    ev(2'b01, 2'b01, 6'd63, 1);
    foreach (addrs[i]) begin
      exp_q.push_back(model[addrs[i]]);
      do_read(addrs[i], d, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || d !== exp) begin
        errors++;
        $display("FAIL bank_read[%02h] got=%0h valid=%b required %0h", addrs[i], d, ok, exp);
      end
    end
    @(negedge clk);
    checks++;
    if (event_count !== m_event) begin
      errors++;
      $display("FAIL bank_event_count got=%0d required %0d", event_count, m_event);
    end
  endtask

  task automatic test_coinc_drop;
    logic [7:0] addrs [4];
    logic [CW-1:0] d, exp;
    bit ok;
    addrs = '{8'h00, 8'h40, 8'h80, 8'hC0};
    ev(2'b00, 2'b11, 6'd0, 1);
    ev(2'b00, 2'b10, 6'd3, 2);
    ev(2'b11, 2'b01, 6'd4, 1);
    ev(2'b10, 2'b11, 6'd5, 1);
    @(negedge clk);
    checks++;
    if (coinc_count !== m_coinc) begin
      errors++;
      $display("FAIL coinc_count got=%0d required %0d", coinc_count, m_coinc);
    end
    checks++;
    if (drop_count !== m_drop) begin
      errors++;
      $display("FAIL drop_count got=%0d required %0d", drop_count, m_drop);
    end
    checks++;
    if (event_count !== m_event) begin
      errors++;
      $display("FAIL coinc_event_count got=%0d required %0d", event_count, m_event);
    end
    foreach (addrs[i]) begin
      exp_q.push_back(model[addrs[i]]);
      do_read(addrs[i], d, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || d !== exp) begin
        errors++;
        $display("FAIL coinc_read[%02h] got=%0h valid=%b required %0h", addrs[i], d, ok, exp);
      end
    end
  endtask

  // Two events to 0x45 two cycles apart with a host read requested in between.
  task automatic test_back_to_back;
    logic [CW-1:0] exp;
    int ack_at = -1;
    bump(8'h45);
    bump(8'h45);
    m_event = m_event + 2;
    exp_q.push_back(model[8'h45]);
    START_signal = 2'b01; END_signal = 2'b10; INTERVAL = 6'd5;
    data_arrived = 1'b1;
    tick;
    data_arrived = 1'b0;
    rd_req = 1'b1;
    rd_addr = 8'h45;
    for (int k = 0; k < 20 && ack_at < 0; k++) begin
      data_arrived = (k == 1);
      @(negedge clk);
      if (rd_ack) ack_at = k;
      tick;
    end
    rd_req = 1'b0;
    data_arrived = 1'b0;
    checks++;
    if (ack_at < 1 || ack_at == 2) begin
      errors++;
      $display("FAIL b2b_ack_timing ack_at=%0d required >=1 and not an E1 cycle (0 or 2)", ack_at);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (ack_at < 0 || rd_valid !== 1'b1 || rd_data !== exp) begin
      errors++;
      $display("FAIL b2b_read[45] got=%0h valid=%b required %0h", rd_data, rd_valid, exp);
    end
    tick;
    tick;
    @(negedge clk);
    checks++;
    if (event_count !== m_event) begin
      errors++;
      $display("FAIL b2b_event_count got=%0d required %0d", event_count, m_event);
    end
  endtask

  task automatic test_saturate;
    logic [CW-1:0] d, exp;
    bit ok;
    for (int i = 0; i < (1 << CW) - 1; i++) ev(2'b01, 2'b01, 6'd3, 1);
    exp_q.push_back(model[8'hC3]);
    do_read(8'hC3, d, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || d !== exp) begin
      errors++;
      $display("FAIL sat_preload[C3] got=%0h valid=%b required %0h", d, ok, exp);
    end
    ev(2'b01, 2'b01, 6'd3, 1);
    exp_q.push_back(model[8'hC3]);
    do_read(8'hC3, d, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || d !== exp) begin
      errors++;
      $display("FAIL sat_limit[C3] got=%0h valid=%b required %0h", d, ok, exp);
    end
  endtask

  task automatic test_clear_busy;
    logic [7:0] addrs [4];
    logic [CW-1:0] d, exp;
    bit ok;
    int busy_cycles;
    logic [TW-1:0] drop_mid = '1;
    addrs = '{8'h00, 8'h05, 8'h45, 8'hC3};
    clear = 1'b1;
    tick;
    clear = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) model[i] = '0;
    m_event = '0; m_coinc = '0; m_drop = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_rise busy=%b required 1", busy);
    end
    checks++;
    if (event_count !== m_event || coinc_count !== m_coinc || drop_count !== m_drop) begin
      errors++;
      $display("FAIL clear_totals ev=%0d co=%0d dr=%0d required 0/0/0", event_count, coinc_count, drop_count);
    end
    busy_cycles = busy ? 1 : 0;
    START_signal = 2'b10; END_signal = 2'b01; INTERVAL = 6'd5;
    for (int k = 0; k < 400 && busy; k++) begin
      tick;
      data_arrived = (k == 20 || k == 22 || k == 24);
      clear = (k == 60);  // ignored: sweep already running
      @(negedge clk);
      if (k == 40) drop_mid = drop_count;
      if (busy) busy_cycles++;
    end
    m_event = m_event + 3;
    m_drop = m_drop + 3;
    clear = 1'b0;
    data_arrived = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if (busy_cycles != 256) begin
      errors++;
      $display("FAIL clear_busy_len busy=%0d cycles required 256", busy_cycles);
    end
    checks++;
    if (drop_mid !== '0) begin
      errors++;
      $display("FAIL clear_drop_while_busy drop_count=%0d required 0", drop_mid);
    end
    checks++;
    if (drop_count !== m_drop || event_count !== m_event || coinc_count !== m_coinc) begin
      errors++;
      $display("FAIL clear_after_sweep dr=%0d ev=%0d co=%0d required %0d/%0d/%0d",
               drop_count, event_count, coinc_count, m_drop, m_event, m_coinc);
    end
    foreach (addrs[i]) begin
      exp_q.push_back(model[addrs[i]]);
      do_read(addrs[i], d, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || d !== exp) begin
        errors++;
        $display("FAIL clear_read[%02h] got=%0h valid=%b required %0h", addrs[i], d, ok, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_bank_event;
    test_coinc_drop;
    test_back_to_back;
    test_saturate;
    test_clear_busy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
